mvu_pe_acc: RTL and testbench

Per-PE reduction and accumulation stage placed directly downstream of the SIMD multiplier units inside each processing element of the Matrix-Vector-Multiplication Unit. Sums the SIMD lane products of one beat through a registered adder tree, then accumulates those sums over SF synapse-fold beats. It presents one dot-product result per output neuron on a valid/ready port toward the MVAU output stage.

---
 rtl/mvu_pe_acc_pkg.sv | 23 ++
 rtl/mvu_pe_adder_tree.sv | 19 +
 rtl/mvu_pe_acc.sv | 112 +++++++++++
 tb/tb_mvu_pe_acc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pe_acc_pkg.sv
// Shared definitions for the MVAU per-PE reduction/accumulation stage:
// default dimensions, counter sizing helper and the derived stage states.
package mvu_pe_acc_pkg;

    localparam int unsigned DEF_SIMD  = 2;
    localparam int unsigned DEF_TDSTI = 4;
    localparam int unsigned DEF_SF    = 4;
    localparam int unsigned DEF_TDSTA = 16;

    // Fold counter width; a single-beat fold still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned SF_CNT_W = cnt_width(DEF_SF);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_LAST,
        ST_HOLD
    } pe_state_e;

endpackage

// File: rtl/mvu_pe_adder_tree.sv
// Combinational reduction of one beat of SIMD lane products, each lane
// zero-extended to the accumulator width before summing.
module mvu_pe_adder_tree #(
    parameter int unsigned SIMD  = 2,
    parameter int unsigned TDSTI = 4,
    parameter int unsigned TDSTA = 16
) (
    input  logic [SIMD*TDSTI-1:0] lanes_i,
    output logic [TDSTA-1:0]      sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < int'(SIMD); i++) begin
            sum_o = sum_o + TDSTA'(lanes_i[i*TDSTI +: TDSTI]);
        end
    end

endmodule

// File: rtl/mvu_pe_acc.sv
// Per-PE lane reduction plus synapse-fold accumulation with a valid/ready
// result port; stall freezes the whole pipeline while a result waits.
module mvu_pe_acc
    import mvu_pe_acc_pkg::*;
#(
    parameter int unsigned SIMD  = DEF_SIMD,
    parameter int unsigned TDSTI = DEF_TDSTI,
    parameter int unsigned SF    = DEF_SF,
    parameter int unsigned TDSTA = DEF_TDSTA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_v_i,
    input  logic                  do_mvau_stream_i,
    input  logic [SIMD*TDSTI-1:0] in_simd_i,
    output logic                  stall_o,
    output logic                  out_v_o,
    input  logic                  out_rdy_i,
    output logic [TDSTA-1:0]      out_o
);

    localparam int unsigned      CNT_W    = cnt_width(SF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SF - 1);

    logic [TDSTA-1:0] tree_sum_c;
    logic [TDSTA-1:0] acc_next_c;
    logic [TDSTA-1:0] sum_q, sum_d;
    logic [TDSTA-1:0] acc_q, acc_d;
    logic [TDSTA-1:0] out_q, out_d;
    logic             sum_v_q, sum_v_d;
    logic             out_v_q, out_v_d;
    logic [CNT_W-1:0] sf_cnt_q, sf_cnt_d;
    logic             stall_c;
    logic             accept_c;
    pe_state_e        state_c;

    mvu_pe_adder_tree #(
        .SIMD  (SIMD),
        .TDSTI (TDSTI),
        .TDSTA (TDSTA)
    ) u_tree (
        .lanes_i (in_simd_i),
        .sum_o   (tree_sum_c)
    );

    assign stall_c    = out_v_q & ~out_rdy_i;
    assign accept_c   = in_v_i & do_mvau_stream_i & ~stall_c;
    assign acc_next_c = (sf_cnt_q == '0) ? sum_q : acc_q + sum_q;

    // Stage state is decoded from the counter and handshake, not stored.
    always_comb begin
        if (stall_c) begin
            state_c = ST_HOLD;
        end else if (sf_cnt_q == CNT_LAST) begin
            state_c = ST_LAST;
        end else begin
            state_c = ST_ACCUM;
        end
    end

    always_comb begin
        sum_d    = sum_q;
        sum_v_d  = sum_v_q;
        acc_d    = acc_q;
        sf_cnt_d = sf_cnt_q;
        out_d    = out_q;
        out_v_d  = out_v_q;
        if (state_c != ST_HOLD) begin
            sum_v_d = accept_c;
            if (accept_c) begin
                sum_d = tree_sum_c;
            end
            if (out_rdy_i) begin
                out_v_d = 1'b0;
            end
            // A result loading this cycle overrides the consume-clear above.
            if (sum_v_q) begin
                acc_d = acc_next_c;
                if (state_c == ST_LAST) begin
                    out_d    = acc_next_c;
                    out_v_d  = 1'b1;
                    sf_cnt_d = '0;
                end else begin
                    sf_cnt_d = sf_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            sum_v_q  <= 1'b0;
            acc_q    <= '0;
            sf_cnt_q <= '0;
            out_q    <= '0;
            out_v_q  <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            sum_v_q  <= sum_v_d;
            acc_q    <= acc_d;
            sf_cnt_q <= sf_cnt_d;
            out_q    <= out_d;
            out_v_q  <= out_v_d;
        end
    end

    assign stall_o = stall_c;
    assign out_v_o = out_v_q;
    assign out_o   = out_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Bench for mvu_pe_acc: vector table, hand-written corner sequences and a
// randomized run scored against a fold-sum reference queue.
module tb_mvu_pe_acc;

    localparam int unsigned SF_M   = 4;
    localparam int unsigned MOD_M  = 65536;

    typedef struct {
        logic        v;
        logic [7:0]  simd;
        logic        rdy;
        logic        ev;
        logic [15:0] eo;
        logic        es;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_v;
    logic        do_s;
    logic [7:0]  in_simd;
    logic        out_rdy;

    logic        stall_m, out_v_m;
    logic [15:0] out_m;
    logic        stall_w, out_v_w;
    logic [7:0]  out_w;
    logic        stall_1, out_v_1;
    logic [15:0] out_1;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int fold_cnt;
    int fold_sum;
    int n_cons;

    always #5 clk = ~clk;

    mvu_pe_acc #(.SIMD(2), .TDSTI(4), .SF(4), .TDSTA(16)) u_main (
        .clk(clk), .rst(rst), .in_v_i(in_v), .do_mvau_stream_i(do_s),
        .in_simd_i(in_simd), .stall_o(stall_m), .out_v_o(out_v_m),
        .out_rdy_i(out_rdy), .out_o(out_m)
    );

    mvu_pe_acc #(.SIMD(2), .TDSTI(4), .SF(16), .TDSTA(8)) u_wrap (
        .clk(clk), .rst(rst), .in_v_i(in_v), .do_mvau_stream_i(do_s),
        .in_simd_i(in_simd), .stall_o(stall_w), .out_v_o(out_v_w),
        .out_rdy_i(out_rdy), .out_o(out_w)
    );

    mvu_pe_acc #(.SIMD(2), .TDSTI(4), .SF(1), .TDSTA(16)) u_sf1 (
        .clk(clk), .rst(rst), .in_v_i(in_v), .do_mvau_stream_i(do_s),
        .in_simd_i(in_simd), .stall_o(stall_1), .out_v_o(out_v_1),
        .out_rdy_i(out_rdy), .out_o(out_1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        fold_cnt = 0;
        fold_sum = 0;
        n_cons   = 0;
    endtask

    // Reference: each group of SF accepted beats yields the sum of all lanes mod 2^16.
    task automatic model_beat(input logic [7:0] s);
        fold_sum += int'(s[3:0]) + int'(s[7:4]);
        fold_cnt++;
        if (fold_cnt == int'(SF_M)) begin
            exp_q.push_back(fold_sum % int'(MOD_M));
            fold_cnt = 0;
            fold_sum = 0;
        end
    endtask

    // One clock: drive, score the handshake for u_main, advance, settle.
    task automatic cycle(input logic v, input logic [7:0] s, input logic d,
                         input logic r, output logic acc);
        in_v    = v;
        in_simd = s;
        do_s    = d;
        out_rdy = r;
        #1;
        acc = v & d & ~stall_m;
        if (acc) model_beat(s);
        if (out_v_m && r) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0d expected=none", out_m);
            end else begin
                chk("result", 32'(out_m), 32'(exp_q.pop_front()));
                n_cons++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_v    = 1'b0;
        do_s    = 1'b1;
        in_simd = '0;
        out_rdy = 1'b1;
        rst     = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t row(input logic v, input logic [7:0] s, input logic r,
                                 input logic ev, input logic [15:0] eo, input logic es);
        vec_t t;
        t.v = v; t.simd = s; t.rdy = r; t.ev = ev; t.eo = eo; t.es = es;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[16];
        logic        a;
        logic        seen;
        logic [7:0]  bp[8];
        logic        pat[12];
        logic        cv, cd, cr, hold;
        logic [7:0]  cs;
        int          bi;
        logic        ev1;

        // Basic fold {3,5}x4 -> 32, then back-to-back {1,2}x4 -> 12, {15,15}x4 -> 120.
        for (int i = 0; i < 4; i++) tbl[i] = row(1'b1, 8'h53, 1'b1, 1'b0, 16'd0, 1'b0);
        tbl[4] = row(1'b0, 8'h00, 1'b1, 1'b1, 16'd32, 1'b0);
        tbl[5] = row(1'b0, 8'h00, 1'b1, 1'b0, 16'd32, 1'b0);
        for (int i = 6; i < 10; i++) tbl[i] = row(1'b1, 8'h21, 1'b1, 1'b0, 16'd32, 1'b0);
        tbl[10] = row(1'b1, 8'hFF, 1'b1, 1'b1, 16'd12, 1'b0);
        for (int i = 11; i < 14; i++) tbl[i] = row(1'b1, 8'hFF, 1'b1, 1'b0, 16'd12, 1'b0);
        tbl[14] = row(1'b0, 8'h00, 1'b1, 1'b1, 16'd120, 1'b0);
        tbl[15] = row(1'b0, 8'h00, 1'b1, 1'b0, 16'd120, 1'b0);

        rst = 1'b1; in_v = 1'b0; do_s = 1'b1; in_simd = '0; out_rdy = 1'b1;
        model_clear();
        #1;
        chk("reset_out_v", 32'(out_v_m), 32'd0);
        chk("reset_out", 32'(out_m), 32'd0);
        chk("reset_stall", 32'(stall_m), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            cycle(tbl[k].v, tbl[k].simd, 1'b1, tbl[k].rdy, a);
            chk($sformatf("tbl%0d_out_v", k), 32'(out_v_m), 32'(tbl[k].ev));
            chk($sformatf("tbl%0d_out", k), 32'(out_m), 32'(tbl[k].eo));
            chk($sformatf("tbl%0d_stall", k), 32'(stall_m), 32'(tbl[k].es));
        end
        chk("tbl_results", 32'(n_cons), 32'd3);

        // Asynchronous reset mid-run with a result pending and a partial fold in flight.
        do_reset();
        for (int c = 0; c < 6; c++) cycle(1'b1, (c < 4) ? 8'h53 : 8'h21, 1'b1, 1'b0, a);
        chk("pre_rst_out_v", 32'(out_v_m), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_v", 32'(out_v_m), 32'd0);
        chk("mid_rst_out", 32'(out_m), 32'd0);
        chk("mid_rst_stall", 32'(stall_m), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 8'h11, 1'b1, 1'b1, a);
            chk("post_rst_no_v", 32'(out_v_m), 32'd0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
        chk("post_rst_out_v", 32'(out_v_m), 32'd1);
        chk("post_rst_out", 32'(out_m), 32'd8);

        // Backpressure: result held for 5 cycles, upstream holds its beat.
        do_reset();
        for (int i = 0; i < 8; i++) bp[i] = (i < 4) ? 8'h53 : 8'h21;
        bi = 0;
        for (int c = 0; c < 30; c++) begin
            if (bi < 8) cycle(1'b1, bp[bi], 1'b1, (c >= 10), a);
            else        cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
            if (a) bi++;
            if (c >= 4 && c <= 9) begin
                chk("bp_stall", 32'(stall_m), 32'd1);
                chk("bp_out_v", 32'(out_v_m), 32'd1);
                chk("bp_out", 32'(out_m), 32'd32);
            end
        end
        chk("bp_beats", 32'(bi), 32'd8);
        chk("bp_results", 32'(n_cons), 32'd2);
        chk("bp_queue", 32'(exp_q.size()), 32'd0);

        // Wrap: 16 beats of 30 into an 8-bit accumulator.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'hFF, 1'b1, 1'b1, a);
            chk("wrap_early_v", 32'(out_v_w), 32'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
            if (out_v_w) begin
                chk("wrap_out", 32'(out_w), 32'd224);
                seen = 1'b1;
                break;
            end
        end
        chk("wrap_seen", 32'(seen), 32'd1);

        // SF=1 with bubbles and a short continuous burst.
        do_reset();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 12; k++) begin
            cycle(pat[k], 8'h07, 1'b1, 1'b1, a);
            ev1 = (k >= 1) ? pat[k-1] : 1'b0;
            chk("sf1_out_v", 32'(out_v_1), 32'(ev1));
            if (ev1) chk("sf1_out", 32'(out_1), 32'd7);
        end

        // Randomized traffic with random backpressure and stream enable.
        do_reset();
        cv = 1'b0; cd = 1'b1; cs = '0; hold = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                cv = ($urandom_range(0, 3) != 0);
                cd = ($urandom_range(0, 7) != 0);
                cs = 8'($urandom);
            end
            cr = ($urandom_range(0, 2) != 0);
            cycle(cv, cs, cd, cr, a);
            hold = cv & cd & ~a;
        end
        for (int k = 0; k < 10; k++) cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("rand_out_v_idle", 32'(out_v_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
